// File: rtl/andor_vector_driver_pkg.sv
// -----------------------------------------------------------------------------
// andor_pkg
// Shared definitions for the AND-OR vector driver and its golden model:
//   - state_t     : sweep FSM state encoding (IDLE/SETTLE/CHECK/DONE)
//   - VEC_W       : width of the stimulus vector {a,b,c,d}
//   - LAST_VEC    : final vector of a sweep
//   - andor_ref() : expected response y = (a&b)|(c&d) for a vector
// -----------------------------------------------------------------------------
package andor_pkg;

  localparam int unsigned VEC_W = 4;
  localparam logic [VEC_W-1:0] LAST_VEC = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Vector bit order is {a,b,c,d} = vec[3:0].
  function automatic logic andor_ref(input logic [VEC_W-1:0] vec);
    return (vec[3] & vec[2]) | (vec[1] & vec[0]);
  endfunction

endpackage

// File: rtl/andor_vector_driver_ref_model.sv
// -----------------------------------------------------------------------------
// andor_ref_model
// Combinational golden model of the AND-OR block.
// Ports:
//   vec [3:0] in  : stimulus vector {a,b,c,d}
//   exp       out : expected y = (a&b)|(c&d)
// -----------------------------------------------------------------------------
module andor_ref_model
  import andor_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             exp
);

  assign exp = andor_ref(vec);

endmodule

// File: rtl/andor_vector_driver.sv
// -----------------------------------------------------------------------------
// andor_vector_driver
// Stimulus/checker end of the AND-OR interface. On a start pulse it sweeps all
// 16 vectors on {a,b,c,d}, holds each for SETTLE_CYCLES cycles, samples y_in
// for one cycle and compares it against the internal reference. At the end it
// pulses done and reports pass, err_count and first_fail_vec.
//
// Parameters:
//   SETTLE_CYCLES : cycles each vector is held before sampling (1..15)
// Ports:
//   clk            in  : clock, rising edge
//   rst_n          in  : asynchronous active-low reset
//   start          in  : begins a sweep when seen in IDLE
//   a,b,c,d        out : stimulus, {a,b,c,d} = current vector
//   y_in           in  : response from the external AND-OR block
//   busy           out : high while sweeping (SETTLE/CHECK)
//   done           out : one-cycle pulse at end of sweep
//   pass           out : 1 iff the last sweep saw no mismatch
//   err_count [4:0] out: mismatches in the last sweep (0..16)
//   first_fail_vec [3:0] out: vector of the first mismatch, 0 if none
// Build option:
//   ANDOR_STOP_ON_FAIL_EN : when defined, the sweep ends at the first mismatch
// -----------------------------------------------------------------------------
module andor_vector_driver
  import andor_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail_vec
);

  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state_r, state_nxt;
  logic [VEC_W-1:0] vec_r, vec_nxt;
  logic [3:0]       wait_cnt_r, wait_cnt_nxt;
  logic [4:0]       err_count_r, err_count_nxt;
  logic [3:0]       first_fail_r, first_fail_nxt;
  logic             fail_seen_r, fail_seen_nxt;
  logic             pass_r, pass_nxt;
  logic             busy_r, done_r;
  logic             exp_s;
  logic             mismatch_s;
  logic             sweep_end_s;

  andor_ref_model u_ref (
    .vec (vec_r),
    .exp (exp_s)
  );

  // Compare the response; an unknown y_in falls to the else branch and counts as a mismatch.
  always_comb begin
    mismatch_s = 1'b1;
    if (y_in == exp_s) begin
      mismatch_s = 1'b0;
    end else begin
      mismatch_s = 1'b1;
    end
  end

  // Decide whether the current CHECK cycle is the last one of the sweep.
  always_comb begin
`ifdef ANDOR_STOP_ON_FAIL_EN
    sweep_end_s = mismatch_s || (vec_r == LAST_VEC);
`else
    sweep_end_s = (vec_r == LAST_VEC);
`endif
  end

  // Next-state and next-datapath logic of the sweep FSM.
  always_comb begin
    state_nxt      = state_r;
    vec_nxt        = vec_r;
    wait_cnt_nxt   = wait_cnt_r;
    err_count_nxt  = err_count_r;
    first_fail_nxt = first_fail_r;
    fail_seen_nxt  = fail_seen_r;
    pass_nxt       = pass_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          vec_nxt        = 4'h0;
          err_count_nxt  = 5'd0;
          first_fail_nxt = 4'h0;
          fail_seen_nxt  = 1'b0;
          pass_nxt       = 1'b0;
          wait_cnt_nxt   = SETTLE_RELOAD;
          state_nxt      = ST_SETTLE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (wait_cnt_r == 4'd0) begin
          state_nxt = ST_CHECK;
        end else begin
          wait_cnt_nxt = wait_cnt_r - 4'd1;
        end
      end
      ST_CHECK: begin
        if (mismatch_s) begin
          err_count_nxt = err_count_r + 5'd1;
          if (!fail_seen_r) begin
            first_fail_nxt = vec_r;
            fail_seen_nxt  = 1'b1;
          end else begin
            first_fail_nxt = first_fail_r;
            fail_seen_nxt  = 1'b1;
          end
        end else begin
          err_count_nxt = err_count_r;
        end
        if (sweep_end_s) begin
          // pass is produced on DONE entry so it is valid alongside done.
          pass_nxt  = (err_count_nxt == 5'd0);
          state_nxt = ST_DONE;
        end else begin
          vec_nxt      = vec_r + 4'd1;
          wait_cnt_nxt = SETTLE_RELOAD;
          state_nxt    = ST_SETTLE;
        end
      end
      ST_DONE: begin
        pass_nxt  = (err_count_r == 5'd0);
        vec_nxt   = 4'h0;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      vec_r        <= 4'h0;
      wait_cnt_r   <= 4'd0;
      err_count_r  <= 5'd0;
      first_fail_r <= 4'h0;
      fail_seen_r  <= 1'b0;
      pass_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      vec_r        <= vec_nxt;
      wait_cnt_r   <= wait_cnt_nxt;
      err_count_r  <= err_count_nxt;
      first_fail_r <= first_fail_nxt;
      fail_seen_r  <= fail_seen_nxt;
      pass_r       <= pass_nxt;
      busy_r       <= (state_nxt == ST_SETTLE) || (state_nxt == ST_CHECK);
      done_r       <= (state_nxt == ST_DONE);
    end
  end

  assign a              = vec_r[3];
  assign b              = vec_r[2];
  assign c              = vec_r[1];
  assign d              = vec_r[0];
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_count_r;
  assign first_fail_vec = first_fail_r;

endmodule

// File: tb/tb_andor_vector_driver.sv
// -----------------------------------------------------------------------------
// tb_andor_vector_driver
// Emulates the external AND-OR block as a 16-entry truth table (correct or
// faulty), issues sweeps, and checks the driver through a scoreboard queue
// consumed by a negedge monitor.
// -----------------------------------------------------------------------------
module tb_andor_vector_driver;

  localparam int S    = 3;
  localparam int FULL = 16 * (S + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       a, b, c, d;
  logic       y_in;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic [3:0] first_fail_vec;
  logic [15:0] tt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mon_k;

  typedef struct {
    int start_edge;
    int lat;
    int errs;
    int first;
    int pass;
  } exp_t;

  exp_t q[$];

  andor_vector_driver #(.SETTLE_CYCLES(S)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .a              (a),
    .b              (b),
    .c              (c),
    .d              (d),
    .y_in           (y_in),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_vec (first_fail_vec)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The external block: response looked up from the current truth table.
  assign y_in = tt[{a, b, c, d}];

  function automatic logic [15:0] ideal_table();
    logic [15:0] t;
    t = 16'h0000;
    for (int v = 0; v < 16; v++) begin
      t[v] = (((v / 8) % 2 == 1) && ((v / 4) % 2 == 1)) ||
             (((v / 2) % 2 == 1) && (v % 2 == 1));
    end
    return t;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t predict(input int se);
    exp_t        e;
    logic [15:0] diff;
    int          n;
    int          first;
    diff  = tt ^ ideal_table();
    n     = 0;
    first = -1;
    for (int v = 0; v < 16; v++) begin
      if (diff[v]) begin
        n++;
        if (first < 0) first = v;
      end
    end
    e.start_edge = se;
    e.first      = (first < 0) ? 0 : first;
    e.pass       = (n == 0) ? 1 : 0;
`ifdef ANDOR_STOP_ON_FAIL_EN
    e.errs = (n > 0) ? 1 : 0;
    e.lat  = (n > 0) ? (first + 1) * (S + 1) : FULL;
`else
    e.errs = n;
    e.lat  = FULL;
`endif
    return e;
  endfunction

  // Monitor: compares the DUT against the head of the scoreboard every negedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && (cyc - q[0].start_edge) >= 0) begin
        mon_k = cyc - q[0].start_edge;
        if (mon_k < q[0].lat) begin
          check("busy_in_sweep", busy, 1);
          check("done_early", done, 0);
          check("vector", {a, b, c, d}, mon_k / (S + 1));
        end else begin
          check("done_at_latency", done, 1);
          check("busy_at_done", busy, 0);
          check("err_count", err_count, q[0].errs);
          check("first_fail_vec", first_fail_vec, q[0].first);
          check("pass", pass, q[0].pass);
          void'(q.pop_front());
        end
      end else begin
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
      end
    end
  end

  task automatic wait_drain(input int bound);
    int waited;
    waited = 0;
    while (q.size() > 0 && waited < bound) begin
      @(negedge clk);
      waited++;
    end
    check("sweep_timeout", q.size(), 0);
    q.delete();
  endtask

  task automatic run_sweep(input logic [15:0] t, input bit extra);
    exp_t e;
    tt = t;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    start = 1'b1;
    e = predict(cyc + 1);
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (extra) begin
      // Second pulse lands while busy or in DONE and must be ignored.
      repeat ($urandom_range(1, e.lat - 1)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_drain(e.lat + 20);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_abcd"}, {a, b, c, d}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_first_fail_vec"}, first_fail_vec, 0);
  endtask

  initial begin
    exp_t e;
    int   s0;
    tt = ideal_table();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed fault patterns.
    run_sweep(ideal_table(), 1'b1);
    run_sweep(16'h0000, 1'b0);
    run_sweep(16'hFFFF, 1'b1);
    run_sweep(16'hF000, 1'b0);   // y = a&b only: wrong at vectors 3, 7, B

    // Random single-bit faults and random tables.
    for (int i = 0; i < 4; i++) begin
      run_sweep(ideal_table() ^ (16'h0001 << $urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 5; i++) begin
      run_sweep(16'($urandom), 1'($urandom_range(0, 1)));
    end

    // start held high: re-triggers only after DONE returns to IDLE.
    tt = ideal_table() ^ 16'h0080;
    @(negedge clk);
    start = 1'b1;
    e = predict(cyc + 1);
    q.push_back(e);
    e = predict(e.start_edge + e.lat + 2);
    q.push_back(e);
    repeat (q[0].lat + 3) @(negedge clk);
    start = 1'b0;
    wait_drain(2 * FULL + 40);

    // Mid-sweep re-start then asynchronous reset.
`ifdef ANDOR_STOP_ON_FAIL_EN
    tt = ideal_table();
`else
    tt = 16'h0000;
`endif
    @(negedge clk);
    start = 1'b1;
    s0 = cyc + 1;
    q.push_back(predict(s0));
    @(negedge clk);
    start = 1'b0;
    while (cyc - s0 < 5 * (S + 1)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc - s0 < 9 * (S + 1) + 1) @(negedge clk);
`ifndef ANDOR_STOP_ON_FAIL_EN
    check("err_before_reset", err_count, 2);
`endif
    #2 rst_n = 1'b0;
    q.delete();
    #1 check_reset_outputs("midsweep_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (FULL) @(negedge clk);   // monitor flags any stray done/busy here

    // Clean sweep after reset.
    run_sweep(ideal_table(), 1'b0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete (t=%0t)", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/andor_vector_driver.md
Name: andor_vector_driver

Overview:
- Self-checking stimulus end of the AND-OR interface. It drives the four inputs {a,b,c,d} of an external combinational y = (a&b)|(c&d) block and samples that block's y.
- It sweeps all 16 input vectors, compares each response against an internal reference, and reports the result: pass flag, error count and first failing vector.
- It sits beside the AND-OR DUT on a lab board or in a bench, started by a single pulse.

Parameters:
- SETTLE_CYCLES, 1, cycles each vector is held before y_in is sampled; legal range 1..15.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins a sweep when sampled high in IDLE; ignored otherwise.
- a  output  1  stimulus bit, equals vec[3].
- b  output  1  stimulus bit, equals vec[2].
- c  output  1  stimulus bit, equals vec[1].
- d  output  1  stimulus bit, equals vec[0].
- y_in  input  1  response from the AND-OR DUT.
- busy  output  1  high in SETTLE and CHECK.
- done  output  1  one-cycle pulse, high in DONE.
- pass  output  1  registered in DONE; 1 iff err_count==0. Held until the next start.
- err_count  output  5  count of mismatches in the last sweep, 0..16.
- first_fail_vec  output  4  vector of the first mismatch; 0 if none.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, vec=0 (a=b=c=d=0), busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, wait_cnt=0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: when start=1 at an edge:
  - vec<=0, err_count<=0, first_fail_vec<=0, fail_seen<=0.
  - wait_cnt<=SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: outputs hold vec. If wait_cnt==0, go to CHECK; else decrement. Duration is exactly SETTLE_CYCLES cycles.
- CHECK (1 cycle):
  - exp = (vec[3]&vec[2])|(vec[1]&vec[0]).
  - If y_in!=exp: err_count++; if !fail_seen, set first_fail_vec<=vec and fail_seen<=1.
  - If vec==4'hF, go to DONE. Otherwise vec<=vec+1, reload wait_cnt, go to SETTLE.
- DONE (1 cycle): pass<=(err_count==0, including any increment made in the final CHECK); vec<=0; go to IDLE.
- Latency: done goes high at edge 16*(SETTLE_CYCLES+1) after the start-sampling edge (edge 32 for S=1).
- Arithmetic:
  - err_count is 5 bits and cannot exceed 16, so it needs no saturation.
  - vec is 4 bits; wrap from F to 0 never occurs because DONE intercepts it.
- Boundaries:
  - start while busy or in DONE is ignored.
  - start held high re-triggers only after returning to IDLE.
  - y_in is sampled only in CHECK.
  - X on y_in counts as a mismatch.
  - rst_n low mid-sweep immediately forces all reset values; no done pulse is produced.

Optional Feature:
- Macro ANDOR_STOP_ON_FAIL_EN.
- Defined: a mismatch in CHECK goes directly to DONE after recording it, so err_count ≤ 1 and pass=0.
- Undefined: the full 16-vector sweep always runs.

Decomposition:
- Package andor_pkg contains:
  - state encoding constants ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_CHECK=2'd2, ST_DONE=2'd3;
  - VEC_W=4 and LAST_VEC=4'hF;
  - function andor_ref(vec) returning the expected y.
- One sub-module, andor_ref_model: combinational, input vec[3:0], output exp. It is shared with the benches as a golden model.

Test Plan:
- Correct DUT, S=1, start pulse -> done at edge 32, pass=1, err_count=0, first_fail_vec=0; a..d step 0..F, each held 2 cycles.
- y_in stuck at 0 -> err_count=7, first_fail_vec=4'h3, pass=0.
- y_in stuck at 1 -> err_count=9, first_fail_vec=4'h0, pass=0.
- Faulty DUT y=a&b only, S=3 -> err_count=3 (vectors 3,7,B), first_fail_vec=4'h3, done at edge 64.
- start re-pulsed at vec=5, then rst_n low at vec=9 -> second start ignored; on reset, outputs are all 0 and state is IDLE with no done pulse; a new start then runs a clean sweep.
- With ANDOR_STOP_ON_FAIL_EN, y_in stuck at 0, S=1 -> done at edge 8, err_count=1, first_fail_vec=4'h3, pass=0.
